// File: rtl/alu_control_muldiv.sv
// alu_control_muldiv: EX-stage ALU op decoder plus an iterative MUL/DIV/REM engine with a pipeline stall handshake
module alu_control_muldiv #(
  parameter int WIDTH = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [9:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [3:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] md_result_o,
  output logic             md_done_o,
  output logic             stall_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] AND_OP = 4'd0, OR_OP = 4'd1, ADD_OP = 4'd2, SUB_OP = 4'd3, XOR_OP = 4'd4;
  localparam logic [3:0] SLL_OP = 4'd5, SRA_OP = 4'd6, MUL_OP = 4'd7, DIV_OP = 4'd8, REM_OP = 4'd9;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [3:0] op;
  logic [WIDTH-1:0] acc, opa, opb, special_val, mul_n, quo_n, rem_n, res_n, mag1, mag2;
  logic [WIDTH:0] diff;
  logic neg_q, neg_r, special, start, is_special;
  logic [6:0] f7;
  logic [2:0] f3;
  assign f7 = funct_i[9:3];
  assign f3 = funct_i[2:0];
  always_comb begin
    ALUCtrl_o = ADD_OP;
    case (ALUOp_i)
      2'b01: ALUCtrl_o = SUB_OP;
      2'b10:
        case (f7)
          7'b0000000: ALUCtrl_o = f3 == 3'b111 ? AND_OP : f3 == 3'b110 ? OR_OP : f3 == 3'b100 ? XOR_OP :
                                  f3 == 3'b001 ? SLL_OP : ADD_OP;
          7'b0100000: ALUCtrl_o = f3 == 3'b000 ? SUB_OP : f3 == 3'b101 ? SRA_OP : ADD_OP;
          7'b0000001: ALUCtrl_o = f3 == 3'b000 ? MUL_OP : f3 == 3'b100 ? DIV_OP : f3 == 3'b110 ? REM_OP : ADD_OP;
          default: ;
        endcase
      2'b11: ALUCtrl_o = f3 == 3'b111 ? AND_OP : f3 == 3'b110 ? OR_OP : f3 == 3'b100 ? XOR_OP :
                         f3 == 3'b001 ? SLL_OP : (f3 == 3'b101 && f7 == 7'b0100000) ? SRA_OP : ADD_OP;
      default: ;
    endcase
  end
  assign start = valid_i && !flush_i && state == IDLE &&
                 (ALUCtrl_o == MUL_OP || ALUCtrl_o == DIV_OP || ALUCtrl_o == REM_OP);
  assign stall_o = !rst_i && !flush_i && (start || state == BUSY);
  assign md_done_o = state == DONE && !flush_i;
  assign mag1 = data1_i[WIDTH-1] ? -data1_i : data1_i;
  assign mag2 = data2_i[WIDTH-1] ? -data2_i : data2_i;
  assign is_special = ALUCtrl_o != MUL_OP && (data2_i == '0 || (data1_i == MIN && data2_i == '1));
  // restoring step: shift next dividend bit into the partial remainder and try subtracting the divisor
  assign diff = {acc, opa[WIDTH-1]} - {1'b0, opb};
  assign rem_n = diff[WIDTH] ? {acc[WIDTH-2:0], opa[WIDTH-1]} : diff[WIDTH-1:0];
  assign quo_n = {opa[WIDTH-2:0], !diff[WIDTH]};
  assign mul_n = acc + (opb[0] ? opa : '0);
  assign res_n = special ? special_val : op == MUL_OP ? mul_n : op == DIV_OP ? (neg_q ? -quo_n : quo_n) :
                 (neg_r ? -rem_n : rem_n);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= '0;
      md_result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state <= BUSY;
            count <= (EARLY_OUT && is_special) ? CW'(1) : CW'(WIDTH);
            op <= ALUCtrl_o;
            acc <= '0;
            opa <= ALUCtrl_o == MUL_OP ? data1_i : mag1;
            opb <= ALUCtrl_o == MUL_OP ? data2_i : mag2;
            neg_q <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
            neg_r <= data1_i[WIDTH-1];
            special <= is_special;
            special_val <= data2_i == '0 ? (ALUCtrl_o == DIV_OP ? '1 : data1_i) : (ALUCtrl_o == DIV_OP ? MIN : '0);
          end
        BUSY: begin
          count <= count - CW'(1);
          acc <= op == MUL_OP ? mul_n : rem_n;
          opa <= op == MUL_OP ? opa << 1 : quo_n;
          opb <= op == MUL_OP ? opb >> 1 : opb;
          if (count == CW'(1)) begin
            state <= DONE;
            md_result_o <= res_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_muldiv.sv
// tb_alu_control_muldiv: scoreboard bench for the ALU decoder and the multi-cycle MUL/DIV/REM engine
module tb_alu_control_muldiv;
  logic clk = 1'b0, rst, valid, flush;
  logic [9:0] funct;
  logic [1:0] aluop;
  logic [31:0] d1, d2, md_result;
  logic [3:0] ctrl;
  logic done, stall;
  typedef struct {
    logic [31:0] res;
    int done_cyc;
    int stalls;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int passed = 0, total = 0, stall_cnt = 0, cyc = 0;

  alu_control_muldiv #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush), .funct_i(funct), .ALUOp_i(aluop),
    .data1_i(d1), .data2_i(d2), .ALUCtrl_o(ctrl), .md_result_o(md_result), .md_done_o(done), .stall_o(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 == 3'b000) return a * b;
    if (b == 32'd0) return f3 == 3'b100 ? 32'hFFFFFFFF : a;
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return f3 == 3'b100 ? 32'h80000000 : 32'd0;
    return f3 == 3'b100 ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [9:0] f);
    if (op == 2'b00) return 4'd2;
    if (op == 2'b01) return 4'd3;
    if (op == 2'b11 && f[2:0] == 3'b101) return f[9:3] == 7'b0100000 ? 4'd6 : 4'd2;
    if (op == 2'b11) f[9:3] = 7'b0;
    case (f)
      10'b0000000_111: return 4'd0;
      10'b0000000_110: return 4'd1;
      10'b0000000_100: return 4'd4;
      10'b0000000_001: return 4'd5;
      10'b0100000_000: return 4'd3;
      10'b0100000_101: return 4'd6;
      10'b0000001_000: return 4'd7;
      10'b0000001_100: return 4'd8;
      10'b0000001_110: return 4'd9;
      default: return 4'd2;
    endcase
  endfunction

  // monitor: count stall cycles per op and score every md_done_o pulse against the queue
  always @(negedge clk) begin
    if (rst || flush) stall_cnt = 0;
    else begin
      if (stall) stall_cnt++;
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e_m = q.pop_front();
          check({e_m.name, "_result"}, md_result, e_m.res);
          check({e_m.name, "_done_cycle"}, 32'(cyc), 32'(e_m.done_cyc));
          check({e_m.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e_m.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic start_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit track);
    bit early;
    valid = 1'b1; funct = {7'b0000001, f3}; aluop = 2'b10; d1 = a; d2 = b;
    #1;
    check({name, "_start_stall"}, 32'(stall), 32'd1);
    early = f3 != 3'b000 && (b == 32'd0 || (a == 32'h80000000 && b == 32'hFFFFFFFF));
    if (track) q.push_back('{res: ref_md(f3, a, b), done_cyc: cyc + (early ? 2 : 33), stalls: early ? 2 : 33, name: name});
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    if (q.size() != 0) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string name, input logic [1:0] op, input logic [9:0] f);
    aluop = op; funct = f;
    #1 check(name, 32'(ctrl), 32'(ref_ctrl(op, f)));
  endtask

  initial begin
    logic [2:0] f3s [3];
    logic [6:0] f7s [4];
    logic [2:0] f3;
    logic [31:0] a, b;
    f3s = '{3'b000, 3'b100, 3'b110};
    f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1010101};
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; aluop = '0; d1 = '0; d2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", md_result, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    dec("dec_sra_r", 2'b10, 10'b0100000_101);
    dec("dec_sra_i", 2'b11, 10'b0100000_101);
    dec("dec_srl_i", 2'b11, 10'b0000000_101);
    dec("dec_branch", 2'b01, 10'b0000000_000);
    for (int i = 0; i < 40; i++) begin
      aluop = 2'($urandom_range(0, 3));
      dec("dec_rand", aluop, {f7s[$urandom_range(0, 3)], 3'($urandom_range(0, 7))});
      check("dec_rand_no_stall", 32'(stall), 32'd0);
    end
    start_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 1'b1);
    wait_idle("mul_7_m3");
    start_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle("div_m7_2");
    start_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle("rem_m7_2");
    start_op("div_5_0", 3'b100, 32'd5, 32'd0, 1'b1);
    wait_idle("div_5_0");
    start_op("rem_5_0", 3'b110, 32'd5, 32'd0, 1'b1);
    wait_idle("rem_5_0");
    start_op("div_min_m1", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle("div_min_m1");
    start_op("rem_min_m1", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle("rem_min_m1");
    start_op("mul_b2b_1", 3'b000, 32'd12345, 32'd678, 1'b1);
    wait_idle("mul_b2b_1");
    start_op("mul_b2b_2", 3'b000, 32'hFFFF0001, 32'h00010003, 1'b1);
    wait_idle("mul_b2b_2");
    start_op("mul_flush", 3'b000, 32'd123, 32'd456, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    start_op("div_after_flush", 3'b100, 32'd1000, 32'd7, 1'b1);
    wait_idle("div_after_flush");
    start_op("div_rst", 3'b100, 32'd99999, 32'd13, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_result", md_result, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_stall_after", 32'(stall), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) begin
      f3 = f3s[$urandom_range(0, 2)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($signed(8'($urandom())));
        default: ;
      endcase
      start_op("rnd", f3, a, b, 1'b1);
      wait_idle("rnd");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
